// File: rtl/ts_packet_tx.sv
// ts_packet_tx: MPEG-TS packet transmitter.
//
// Software writes 188-byte packets as 32-bit little-endian words into a
// two-bank ping-pong buffer and commits them. Each committed packet is sent
// as a stream of bytes on a parallel TS interface. The TS clock is a
// divided clock generated from a register.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   system clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_strb  word write into the current write bank
//   pkt_commit                  marks the write bank full and swaps banks
//   tx_enable                   allows new packets to start
//   clk_div                     mpeg_clk half-period in ACLK cycles minus 1 (0 acts as 1)
//   bank_free                   write bank is empty and accepting writes
//   pkt_sent                    one-cycle pulse when a packet's last byte slot ends
//   underrun_cnt                saturating count of starved byte slots
//   mpeg_clk/mpeg_valid/mpeg_sync/mpeg_data  TS byte interface
module ts_packet_tx #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PACKET_WORDS       = 47,
  parameter int CLK_DIV_WIDTH      = 8,
  parameter int UNDERRUN_CNT_WIDTH = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          wr_en,
  input  logic [5:0]                    wr_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb,
  input  logic                          pkt_commit,
  input  logic                          tx_enable,
  input  logic [CLK_DIV_WIDTH-1:0]      clk_div,
  output logic                          bank_free,
  output logic                          pkt_sent,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt,
  output logic                          mpeg_clk,
  output logic                          mpeg_valid,
  output logic                          mpeg_sync,
  output logic [7:0]                    mpeg_data
);

  localparam int PKT_BYTES = PACKET_WORDS * 4;
  localparam int IDX_W     = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_BYTES - 1);
  localparam logic [5:0]       LAST_WORD = 6'(PACKET_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [2][PACKET_WORDS];

  state_t                  state;
  logic [IDX_W-1:0]        idx;         // index of the byte currently on air
  logic [1:0]              full;
  logic [1:0]              full_next;
  logic                    wbank, rbank;
  logic [CLK_DIV_WIDTH-1:0] div_cnt, div_lim, div_eff;
  logic                    div_wrap, slot_start, eop, start_avail, wr_ok;
  logic                    fetch_bank;
  logic [IDX_W-1:0]        fetch_byte;
  logic [C_S_AXI_DATA_WIDTH-1:0] fetch_word;
  logic [7:0]              next_byte;

  assign bank_free   = ~full[wbank];
  assign wr_ok       = wr_en && !full[wbank] && (wr_addr <= LAST_WORD);
  assign div_eff     = (clk_div == '0) ? CLK_DIV_WIDTH'(1) : clk_div;
  assign div_wrap    = (div_cnt == div_lim);
  // A slot starts on the ACLK edge that drives mpeg_clk from 1 to 0.
  assign slot_start  = div_wrap && mpeg_clk;
  assign eop         = slot_start && (state == SEND) && (idx == LAST_IDX);
  // At end of packet the start decision looks at the bank that comes next.
  assign start_avail = (state == SEND) ? full[~rbank] : full[rbank];

  // Address of the byte that the next slot will drive if it carries data.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    fetch_bank = rbank;
    fetch_byte = '0;
    if (state == SEND) begin
      if (idx == LAST_IDX) fetch_bank = ~rbank;
      else                 fetch_byte = idx + IDX_W'(1);
    end
  end

  assign fetch_word = mem[fetch_bank][fetch_byte[IDX_W-1:2]];

  always_comb begin
    full_next = full;
    if (eop) full_next[rbank] = 1'b0;
    if (pkt_commit && !full[wbank]) full_next[wbank] = 1'b1;
  end

  // NOTE: the packet buffer carries no reset; its contents are meaningless
  // until written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_ok) begin
      for (int j = 0; j < C_S_AXI_DATA_WIDTH / 8; j++) begin
        if (wr_strb[j]) mem[wbank][wr_addr][8*j +: 8] <= wr_data[8*j +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state        <= IDLE;
      idx          <= '0;
      full         <= '0;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      div_cnt      <= '0;
      div_lim      <= CLK_DIV_WIDTH'(1);
      next_byte    <= '0;
      pkt_sent     <= 1'b0;
      underrun_cnt <= '0;
      mpeg_clk     <= 1'b0;
      mpeg_valid   <= 1'b0;
      mpeg_sync    <= 1'b0;
      mpeg_data    <= '0;
    end else begin
      pkt_sent  <= 1'b0;
      full      <= full_next;
      // Prefetch every cycle; the fetch address only moves at slot starts,
      // so the byte is settled well before the next slot needs it.
      next_byte <= fetch_word[{fetch_byte[1:0], 3'b000} +: 8];
      if (pkt_commit && !full[wbank]) wbank <= ~wbank;

      // A new clk_div is picked up only when the count wraps.
      if (div_wrap) begin
        div_cnt  <= '0;
        div_lim  <= div_eff;
        mpeg_clk <= ~mpeg_clk;
      end else begin
        div_cnt <= div_cnt + CLK_DIV_WIDTH'(1);
      end

      if (slot_start) begin
        if (eop) begin
          rbank    <= ~rbank;
          pkt_sent <= 1'b1;
        end
        if (state == SEND && !eop) begin
          idx        <= idx + IDX_W'(1);
          mpeg_data  <= next_byte;
          mpeg_valid <= 1'b1;
          mpeg_sync  <= 1'b0;
        end else if (tx_enable && start_avail) begin
          state      <= SEND;
          idx        <= '0;
          mpeg_data  <= next_byte;
          mpeg_valid <= 1'b1;
          mpeg_sync  <= 1'b1;
        end else begin
          state      <= IDLE;
          mpeg_data  <= '0;
          mpeg_valid <= 1'b0;
          mpeg_sync  <= 1'b0;
          if (tx_enable && underrun_cnt != '1)
            underrun_cnt <= underrun_cnt + UNDERRUN_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ts_packet_tx.sv
// Self-checking bench for ts_packet_tx: clock-divider table, directed
// packet sequences, and a randomized run against a packet-level model.
module tb_ts_packet_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        pkt_commit = 1'b0;
  logic        tx_enable = 1'b0;
  logic [7:0]  clk_div = 8'd1;
  logic        bank_free, pkt_sent, mpeg_clk, mpeg_valid, mpeg_sync;
  logic [15:0] underrun_cnt;
  logic [7:0]  mpeg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ts_packet_tx dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .pkt_commit(pkt_commit), .tx_enable(tx_enable), .clk_div(clk_div),
    .bank_free(bank_free), .pkt_sent(pkt_sent), .underrun_cnt(underrun_cnt),
    .mpeg_clk(mpeg_clk), .mpeg_valid(mpeg_valid), .mpeg_sync(mpeg_sync),
    .mpeg_data(mpeg_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  // Committed packets are a flat byte queue; npend counts packets held in
  // the buffer (including the one on air). The writer sees two images.
  logic [7:0] byte_q[$];
  logic [7:0] img[2][188];
  int         npend, wsel, pos, m_div, m_lim, m_under, sent_cnt;
  logic       sending, m_clk, m_valid, m_sync, m_sent;
  logic [7:0] m_data;
  logic       sent_bf[$];

  always @(posedge clk) begin
    int sz;
    #1;
    if (!rst_n) begin
      byte_q.delete();
      npend = 0; wsel = 0; pos = 0; m_div = 0; m_lim = 1; m_under = 0;
      sending = 0; m_clk = 0; m_valid = 0; m_sync = 0; m_sent = 0; m_data = 0;
    end else begin
      sz = npend;
      m_sent = 0;
      if (m_div == m_lim) begin
        m_div = 0;
        m_lim = (clk_div == 0) ? 1 : int'(clk_div);
        if (m_clk) begin
          m_clk = 0;
          if (sending && pos == 188) begin
            sending = 0; npend--; m_sent = 1;
          end
          if (sending) begin
            m_data = byte_q.pop_front(); m_valid = 1; m_sync = 0; pos++;
          end else if (tx_enable && npend > 0) begin
            sending = 1; pos = 1;
            m_data = byte_q.pop_front(); m_valid = 1; m_sync = 1;
          end else begin
            m_valid = 0; m_sync = 0; m_data = 0;
            if (tx_enable && m_under != 16'hFFFF) m_under++;
          end
        end else begin
          m_clk = 1;
        end
      end else begin
        m_div++;
      end
      if (wr_en && sz < 2 && wr_addr < 47)
        for (int j = 0; j < 4; j++)
          if (wr_strb[j]) img[wsel][4*wr_addr + j] = wr_data[8*j +: 8];
      if (pkt_commit && sz < 2) begin
        for (int k = 0; k < 188; k++) byte_q.push_back(img[wsel][k]);
        wsel ^= 1; npend++;
      end
      check("sb_mpeg_clk", 32'(mpeg_clk), 32'(m_clk));
      check("sb_mpeg_valid", 32'(mpeg_valid), 32'(m_valid));
      check("sb_mpeg_sync", 32'(mpeg_sync), 32'(m_sync));
      check("sb_mpeg_data", 32'(mpeg_data), 32'(m_data));
      check("sb_pkt_sent", 32'(pkt_sent), 32'(m_sent));
      check("sb_underrun", 32'(underrun_cnt), 32'(m_under));
      check("sb_bank_free", 32'(bank_free), 32'(npend < 2));
      if (pkt_sent) begin
        sent_cnt++;
        sent_bf.push_back(bank_free);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] pkt_byte(input int p, input int k);
    return (k == 0) ? 8'h47 : 8'(k + 37 * p);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; wr_en = 0; pkt_commit = 0; tx_enable = 0; clk_div = 8'd1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    sent_cnt = 0;
    sent_bf.delete();
  endtask

  task automatic write_word(input int a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    wr_en = 1; wr_addr = 6'(a); wr_data = d; wr_strb = s;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic write_pkt(input int p);
    for (int w = 0; w < 47; w++)
      write_word(w, {pkt_byte(p, 4*w+3), pkt_byte(p, 4*w+2),
                     pkt_byte(p, 4*w+1), pkt_byte(p, 4*w)}, 4'hF);
  endtask

  task automatic commit();
    @(negedge clk); pkt_commit = 1;
    @(negedge clk); pkt_commit = 0;
  endtask

  task automatic next_slot(output logic v, output logic s, output logic [7:0] d);
    logic prev;
    int   n;
    prev = mpeg_clk; n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (prev && !mpeg_clk) break;
      prev = mpeg_clk;
      if (n > 2000) begin
        check("slot_timeout", 32'(n), 32'd2000);
        break;
      end
    end
    v = mpeg_valid; s = mpeg_sync; d = mpeg_data;
  endtask

  // Waits for the first slot carrying data; returns its sync and data.
  task automatic first_valid(input string name, output logic s, output logic [7:0] d);
    logic v;
    int   n;
    n = 0;
    do begin
      next_slot(v, s, d);
      n++;
    end while (!v && n < 8);
    check({name, "_found"}, 32'(v), 32'd1);
  endtask

  task automatic measure_period(output int per);
    int   n, rises, t0;
    logic prev;
    n = 0; rises = 0; t0 = 0; per = 0; prev = mpeg_clk;
    while (rises < 3 && n < 3000) begin
      @(posedge clk); #1; n++;
      if (!prev && mpeg_clk) begin
        rises++;
        if (rises == 2) t0 = n;
        if (rises == 3) per = n - t0;
      end
      prev = mpeg_clk;
    end
  endtask

  typedef struct {
    logic [7:0] div;
    int         period;
  } div_vec_t;

  div_vec_t dv[5];

  initial begin
    logic       v, s;
    logic [7:0] d;
    int         per, u0, nvalid;

    dv[0] = '{8'd0, 4};
    dv[1] = '{8'd1, 4};
    dv[2] = '{8'd2, 6};
    dv[3] = '{8'd7, 16};
    dv[4] = '{8'd255, 512};

    // Reset: outputs forced low while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {23'd0, mpeg_clk, mpeg_valid, mpeg_sync, pkt_sent, mpeg_data}, 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    do_reset();
    @(negedge clk);
    check("rst_bank_free", 32'(bank_free), 32'd1);

    // mpeg_clk period for a table of divider settings.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); clk_div = dv[i].div;
      measure_period(per);
      check($sformatf("period_div%0d", dv[i].div), 32'(per), 32'(dv[i].period));
    end

    // Single packet.
    do_reset();
    write_pkt(0);
    commit();
    repeat (2) @(negedge clk);
    check("single_bank_free", 32'(bank_free), 32'd1);
    tx_enable = 1;
    first_valid("single_first", s, d);
    check("single_sync0", 32'(s), 32'd1);
    check("single_byte0", 32'(d), 32'h47);
    for (int k = 1; k < 188; k++) begin
      next_slot(v, s, d);
      check("single_vs", {30'd0, v, s}, 32'd2);
      check($sformatf("single_byte%0d", k), 32'(d), 32'(pkt_byte(0, k)));
    end
    next_slot(v, s, d);
    check("single_idle_valid", 32'(v), 32'd0);
    u0 = underrun_cnt;
    check("single_under1", 32'(u0), 32'd1);
    next_slot(v, s, d);
    check("single_under2", 32'(underrun_cnt), 32'd2);
    @(negedge clk);
    check("single_sent_cnt", 32'(sent_cnt), 32'd1);

    // Back-to-back packets with both banks full, plus ignored write/commit.
    do_reset();
    write_pkt(1);
    commit();
    write_pkt(2);
    commit();
    @(negedge clk);
    check("full_bank_free", 32'(bank_free), 32'd0);
    write_word(5, 32'hDEADBEEF, 4'hF);
    commit();
    @(negedge clk);
    check("full_still_full", 32'(bank_free), 32'd0);
    tx_enable = 1;
    first_valid("b2b_first", s, d);
    check("b2b_sync0", 32'(s), 32'd1);
    check("b2b_byte0", 32'(d), 32'h47);
    for (int i = 1; i < 376; i++) begin
      next_slot(v, s, d);
      check("b2b_valid", 32'(v), 32'd1);
      check($sformatf("b2b_sync%0d", i), 32'(s), 32'(i % 188 == 0));
      check($sformatf("b2b_byte%0d", i), 32'(d), 32'(pkt_byte(i < 188 ? 1 : 2, i % 188)));
    end
    check("b2b_under_before", 32'(underrun_cnt), 32'd0);
    next_slot(v, s, d);
    check("b2b_idle_valid", 32'(v), 32'd0);
    check("b2b_under_after", 32'(underrun_cnt), 32'd1);
    @(negedge clk);
    check("b2b_sent_cnt", 32'(sent_cnt), 32'd2);
    check("full_free_at_sent", 32'(sent_bf.size() > 0 ? sent_bf[0] : 1'b0), 32'd1);

    // tx_enable dropped mid-packet.
    do_reset();
    write_pkt(3);
    commit();
    write_pkt(4);
    commit();
    tx_enable = 1;
    first_valid("dis_first", s, d);
    for (int k = 1; k <= 100; k++) next_slot(v, s, d);
    check("dis_byte100", 32'(d), 32'(pkt_byte(3, 100)));
    @(negedge clk); tx_enable = 0;
    for (int k = 101; k < 188; k++) begin
      next_slot(v, s, d);
      check($sformatf("dis_byte%0d", k), {23'd0, v, d}, {23'd0, 1'b1, pkt_byte(3, k)});
    end
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      next_slot(v, s, d);
      if (v) nvalid++;
    end
    check("dis_idle_slots", 32'(nvalid), 32'd0);
    check("dis_underrun", 32'(underrun_cnt), 32'd0);
    @(negedge clk);
    check("dis_sent_cnt", 32'(sent_cnt), 32'd1);

    // Reset in the middle of a packet.
    do_reset();
    write_pkt(5);
    commit();
    tx_enable = 1;
    first_valid("mrst_first", s, d);
    for (int k = 1; k <= 50; k++) next_slot(v, s, d);
    for (int n = 0; n < 10 && !mpeg_clk; n++) begin
      @(posedge clk); #1;
    end
    check("mrst_clk_high", 32'(mpeg_clk), 32'd1);
    #2 rst_n = 0;
    #1;
    check("mrst_outputs", {23'd0, mpeg_clk, mpeg_valid, mpeg_sync, pkt_sent, mpeg_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    sent_cnt = 0;
    nvalid = 0;
    for (int k = 0; k < 15; k++) begin
      next_slot(v, s, d);
      if (v) nvalid++;
    end
    check("mrst_no_tx", 32'(nvalid), 32'd0);
    check("mrst_bank_free", 32'(bank_free), 32'd1);
    @(negedge clk);
    check("mrst_no_sent", 32'(sent_cnt), 32'd0);

    // Randomized traffic; the model checks every cycle.
    do_reset();
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      pkt_commit = ($urandom_range(0, 59) == 0);
      wr_en      = !pkt_commit && ($urandom_range(0, 2) == 0);
      wr_addr    = 6'($urandom_range(0, 52));
      wr_data    = $urandom;
      wr_strb    = 4'($urandom);
      if ($urandom_range(0, 299) == 0) tx_enable = ~tx_enable;
      if ($urandom_range(0, 999) == 0) clk_div = 8'($urandom_range(0, 3));
    end
    @(negedge clk);
    wr_en = 0; pkt_commit = 0; tx_enable = 0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
